mode_write_sequencer: RTL and testbench

- Upstream stage of the mode-bit routing mux.
- Accepts a 16-bit mode configuration word over a valid/ready handshake and serialises it into single-bit writes.
- Each write drives the mux's 4-bit select and 1-bit mode_val, one bit position at a time, with a strobe held for a programmable number of cycles.
- Keeps a shadow copy of the programmed mode word. It can optionally skip bits whose value has not changed.

---
 rtl/mode_pkg.sv | 21 ++
 rtl/mode_write_sequencer.sv | 118 +++++++++++
 tb/tb_mode_write_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mode_pkg.sv
// Shared types and constants for the mode-bit write sequencer.
// Step-to-select mapping skips the reserved selects 4'hC..4'hE.
package mode_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD,
        DONE
    } state_t;

    localparam int         MODE_W    = 16;
    localparam int         NUM_STEPS = 13;
    localparam logic [3:0] TOP_SEL   = 4'hF;

    // Steps 0..11 address their own bit; the final step addresses bit 15.
    function automatic logic [3:0] step_to_sel(input logic [3:0] idx);
        return (idx < 4'd12) ? idx : TOP_SEL;
    endfunction

endpackage

// File: rtl/mode_write_sequencer.sv
// Serialises a 16-bit mode word into single-bit mux writes, each strobed
// for HOLD_CYCLES cycles, while tracking the programmed word in a shadow.
module mode_write_sequencer
    import mode_pkg::*;
#(
    parameter int               HOLD_CYCLES    = 2,
    parameter bit               SKIP_UNCHANGED = 1'b1,
    parameter logic [MODE_W-1:0] SHADOW_INIT   = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MODE_W-1:0] cfg_word,
    output logic [3:0]        select,
    output logic              mode_val,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [MODE_W-1:0] shadow
);

    // Bits 12..14 have no select, so they are never stored.
    localparam logic [MODE_W-1:0] VALID_MASK = 16'h8FFF;
    localparam logic [MODE_W-1:0] SHADOW_RST = SHADOW_INIT & VALID_MASK;
    localparam logic [3:0]        HOLD_LOAD  = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0]        LAST_IDX   = 4'(NUM_STEPS);

    state_t            state, state_next;
    logic [3:0]        idx, idx_next;
    logic [3:0]        hold_cnt, hold_next;
    logic [MODE_W-1:0] work, work_next;
    logic [MODE_W-1:0] shadow_q, shadow_next;
    logic [3:0]        select_q, select_next;
    logic              mode_val_q, mode_val_next;
    logic [3:0]        step_sel;
    logic              target_bit;

    assign step_sel   = step_to_sel(idx);
    assign target_bit = work[step_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 4'd0;
            hold_cnt   <= 4'd0;
            work       <= '0;
            shadow_q   <= SHADOW_RST;
            select_q   <= 4'h0;
            mode_val_q <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            hold_cnt   <= hold_next;
            work       <= work_next;
            shadow_q   <= shadow_next;
            select_q   <= select_next;
            mode_val_q <= mode_val_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        hold_next     = hold_cnt;
        work_next     = work;
        shadow_next   = shadow_q;
        select_next   = select_q;
        mode_val_next = mode_val_q;

        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    work_next  = cfg_word & VALID_MASK;
                    idx_next   = 4'd0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else if (SKIP_UNCHANGED && (target_bit == shadow_q[step_sel])) begin
                    idx_next = idx + 4'd1;
                end else begin
                    select_next   = step_sel;
                    mode_val_next = target_bit;
                    hold_next     = HOLD_LOAD;
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                // The shadow is committed only once the full strobe has elapsed.
                if (hold_cnt == 4'd0) begin
                    shadow_next[select_q] = mode_val_q;
                    idx_next              = idx + 4'd1;
                    state_next            = SCAN;
                end else begin
                    hold_next = hold_cnt - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign wr_en     = (state == HOLD);
    assign select    = select_q;
    assign mode_val  = mode_val_q;
    assign shadow    = shadow_q;

endmodule

// File: tb/tb_mode_write_sequencer.sv
// Scoreboard bench: instance a rewrites every bit, instance b skips unchanged bits.
module tb_mode_write_sequencer;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid_a = 1'b0;
    logic        cfg_valid_b = 1'b0;
    logic [15:0] cfg_word = 16'h0000;

    logic        cfg_ready_a, wr_en_a, mode_val_a, busy_a, done_a;
    logic [3:0]  select_a;
    logic [15:0] shadow_a;
    logic        cfg_ready_b, wr_en_b, mode_val_b, busy_b, done_b;
    logic [3:0]  select_b;
    logic [15:0] shadow_b;

    bit          sel_dut = 1'b0;
    logic        mon_cfg_ready, mon_wr_en, mon_mode_val, mon_busy, mon_done;
    logic [3:0]  mon_select;
    logic [15:0] mon_shadow;

    int          vectors = 0;
    int          miscompares = 0;
    logic [4:0]  exp_q[$];
    logic [15:0] model_a = 16'h0000;
    logic [15:0] model_b = 16'h0000;

    bit          in_run = 1'b0;
    int          run_len = 0;
    logic [3:0]  run_sel;
    logic        run_val;

    always #5 clk = ~clk;

    mode_write_sequencer #(.HOLD_CYCLES(HOLD), .SKIP_UNCHANGED(1'b0), .SHADOW_INIT(16'h0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
        .cfg_word(cfg_word), .select(select_a), .mode_val(mode_val_a), .wr_en(wr_en_a),
        .busy(busy_a), .done(done_a), .shadow(shadow_a)
    );

    mode_write_sequencer #(.HOLD_CYCLES(HOLD), .SKIP_UNCHANGED(1'b1), .SHADOW_INIT(16'h0000)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .cfg_word(cfg_word), .select(select_b), .mode_val(mode_val_b), .wr_en(wr_en_b),
        .busy(busy_b), .done(done_b), .shadow(shadow_b)
    );

    assign mon_cfg_ready = sel_dut ? cfg_ready_b : cfg_ready_a;
    assign mon_wr_en     = sel_dut ? wr_en_b     : wr_en_a;
    assign mon_mode_val  = sel_dut ? mode_val_b  : mode_val_a;
    assign mon_busy      = sel_dut ? busy_b      : busy_a;
    assign mon_done      = sel_dut ? done_b      : done_a;
    assign mon_select    = sel_dut ? select_b    : select_a;
    assign mon_shadow    = sel_dut ? shadow_b    : shadow_a;

    // Each write burst pops one expected {select, mode_val} and must last HOLD cycles.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst_n) begin
            in_run = 1'b0;
            exp_q.delete();
        end else if (mon_wr_en) begin
            if (!in_run) begin
                in_run  = 1'b1;
                run_len = 1;
                run_sel = mon_select;
                run_val = mon_mode_val;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_write: got sel=%h val=%b, expected no write", mon_select, mon_mode_val);
                end else begin
                    e = exp_q.pop_front();
                    if ({mon_select, mon_mode_val} !== e)
                        begin
                            miscompares++;
                            $display("[TB] FAIL write_order: got sel=%h val=%b, expected sel=%h val=%b",
                                     mon_select, mon_mode_val, e[4:1], e[0]);
                        end
                end
            end else begin
                run_len++;
                vectors++;
                if (mon_select !== run_sel || mon_mode_val !== run_val) begin
                    miscompares++;
                    $display("[TB] FAIL write_stable: got sel=%h val=%b, expected sel=%h val=%b",
                             mon_select, mon_mode_val, run_sel, run_val);
                end
            end
        end else if (in_run) begin
            in_run = 1'b0;
            vectors++;
            if (run_len != HOLD) begin
                miscompares++;
                $display("[TB] FAIL hold_length: got %0d cycles, expected %0d", run_len, HOLD);
            end
        end
    end

    // Reference model: queues the writes a word should produce and updates the model shadow.
    task automatic push_expected(input bit which, input logic [15:0] word, output int n);
        logic [15:0] sh;
        logic [3:0]  s;
        sh = which ? model_b : model_a;
        n  = 0;
        for (int i = 0; i < 13; i++) begin
            s = (i < 12) ? 4'(i) : 4'hF;
            if (!which || word[s] !== sh[s]) begin
                exp_q.push_back({s, word[s]});
                n++;
            end
        end
        if (which) model_b = word & 16'h8FFF;
        else       model_a = word & 16'h8FFF;
    endtask

    task automatic apply_word(input bit which, input logic [15:0] word, output int n);
        @(negedge clk);
        cfg_word = word;
        if (which) cfg_valid_b = 1'b1;
        else       cfg_valid_a = 1'b1;
        push_expected(which, word, n);
        @(posedge clk);
        #1;
        cfg_valid_a = 1'b0;
        cfg_valid_b = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (mon_done) begin
                cycles    = i;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({wr_en_a, busy_a, done_a, select_a, mode_val_a, shadow_a} !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_a: got wr=%b busy=%b done=%b sel=%h val=%b shadow=%h, expected all zero",
                     wr_en_a, busy_a, done_a, select_a, mode_val_a, shadow_a);
        end
        vectors++;
        if ({wr_en_b, busy_b, done_b, select_b, mode_val_b, shadow_b} !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_b: got wr=%b busy=%b done=%b sel=%h val=%b shadow=%h, expected all zero",
                     wr_en_b, busy_b, done_b, select_b, mode_val_b, shadow_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (cfg_ready_a !== 1'b1 || cfg_ready_b !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_after_reset: got a=%b b=%b, expected 1", cfg_ready_a, cfg_ready_b);
        end
    endtask

    task automatic check_sequence(input string name, input int n, input logic [15:0] exp_shadow);
        int  cycles;
        bit  timed_out;
        wait_done(cycles, timed_out);
        vectors++;
        if (timed_out) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: got no done in 300 cycles, expected done", name);
        end else if (cycles != 15 + n * HOLD) begin
            miscompares++;
            $display("[TB] FAIL %s_latency: got done at cycle %0d, expected %0d", name, cycles, 15 + n * HOLD);
        end
        @(negedge clk);
        vectors++;
        if (mon_shadow !== exp_shadow || mon_busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_end: got shadow=%h busy=%b pending=%0d, expected shadow=%h busy=0 pending=0",
                     name, mon_shadow, mon_busy, exp_q.size(), exp_shadow);
        end
    endtask

    task automatic test_full_write();
        int n;
        sel_dut = 1'b0;
        apply_word(1'b0, 16'h8001, n);
        vectors++;
        if (mon_busy !== 1'b1 || mon_cfg_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL accept_a: got busy=%b ready=%b, expected busy=1 ready=0", mon_busy, mon_cfg_ready);
        end
        check_sequence("full_8001", n, 16'h8001);
    endtask

    task automatic test_skip();
        int n;
        sel_dut = 1'b1;
        apply_word(1'b1, 16'h8001, n);
        check_sequence("skip_8001", n, 16'h8001);
        apply_word(1'b1, 16'h8003, n);
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("[TB] FAIL skip_model_count: got %0d writes, expected 1", n);
        end
        check_sequence("skip_8003", n, 16'h8003);
    endtask

    task automatic test_reserved_bits();
        int n;
        sel_dut = 1'b1;
        apply_word(1'b1, 16'h0000, n);
        check_sequence("clear", n, 16'h0000);
        apply_word(1'b1, 16'h7000, n);
        check_sequence("reserved_7000", n, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int n;
        int cycles;
        bit timed_out;
        bit got_done;
        sel_dut = 1'b1;
        apply_word(1'b1, 16'h00F0, n);
        cfg_valid_b = 1'b1;
        got_done    = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            vectors++;
            if (mon_cfg_ready !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL ready_while_busy: got %b at cycle %0d, expected 0", mon_cfg_ready, i);
            end
            if (mon_done) begin
                got_done = 1'b1;
                vectors++;
                if (i != 15 + n * HOLD) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_first_latency: got %0d, expected %0d", i, 15 + n * HOLD);
                end
                break;
            end
            cfg_word = 16'($urandom);
        end
        vectors++;
        if (!got_done) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_timeout: got no done, expected done");
        end
        cfg_word = 16'h0F00;
        push_expected(1'b1, 16'h0F00, n);
        @(negedge clk);
        vectors++;
        if (mon_cfg_ready !== 1'b1 || mon_busy !== 1'b0 || mon_shadow !== 16'h00F0) begin
            miscompares++;
            $display("[TB] FAIL b2b_idle: got ready=%b busy=%b shadow=%h, expected ready=1 busy=0 shadow=00f0",
                     mon_cfg_ready, mon_busy, mon_shadow);
        end
        @(posedge clk);
        #1;
        cfg_valid_b = 1'b0;
        vectors++;
        if (mon_busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept: got busy=%b, expected 1", mon_busy);
        end
        wait_done(cycles, timed_out);
        vectors++;
        if (timed_out || cycles != 15 + n * HOLD) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_latency: got %0d (timeout=%b), expected %0d", cycles, timed_out, 15 + n * HOLD);
        end
        @(negedge clk);
        vectors++;
        if (mon_shadow !== 16'h0F00 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_shadow: got %h pending=%0d, expected 0f00 pending=0", mon_shadow, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_hold();
        int n;
        bit found;
        sel_dut = 1'b0;
        apply_word(1'b0, 16'h0020, n);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mon_wr_en && mon_select == 4'h5) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL reach_sel5: got no write at select 5, expected one");
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (wr_en_a !== 1'b0 || select_a !== 4'h0 || shadow_a !== 16'h0000 || busy_a !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_hold: got wr=%b sel=%h shadow=%h busy=%b, expected 0 0 0000 0",
                     wr_en_a, select_a, shadow_a, busy_a);
        end
        vectors++;
        if (shadow_b !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL reset_shadow_b: got %h, expected 0000", shadow_b);
        end
        exp_q.delete();
        model_a = 16'h0000;
        model_b = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply_word(1'b0, 16'h0003, n);
        check_sequence("after_reset", n, 16'h0003);
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_skip();
        test_reserved_bits();
        test_back_to_back();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
